// File: rtl/neural_net_seq.sv
// ---------------------------------------------------------------------------
// neural_net_seq
//
// Sequencer for a small neural-net datapath. A learn request streams kernel
// and weight words into their memories; a classify request walks the weight
// memory with the kernel words held on fixed addresses and fires a one-cycle
// start pulse to the datapath. Each completed operation ends with a
// one-cycle done pulse. Abort drops the current operation without a done
// pulse.
//
// Parameters
//   ADDR_W   memory address width
//   N_KERN   kernel words per learn, also the kernel-memory port count
//   W_WORDS  weight words per learn/classify
//   W_PORTS  weight-memory port count (must divide W_WORDS)
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   learn     in   learn request (sampled in IDLE)
//   classify  in   classify request (sampled in IDLE, learn has priority)
//   abort     in   terminate current LEARN/CLASSIFY
//   busy      out  high while in LEARN or CLASSIFY
//   done      out  one-cycle completion pulse
//   en        out  classify-start pulse to the datapath
//   kmem_a    out  kernel addresses, port k at [k*ADDR_W +: ADDR_W]
//   kmem_web  out  kernel active-low write enables
//   kmem_csb, kmem_oeb  out  kernel chip/output enables (tied low)
//   wmem_a    out  weight addresses, port p at [p*ADDR_W +: ADDR_W]
//   wmem_web  out  weight active-low write enables
//   wmem_csb, wmem_oeb  out  weight chip/output enables (tied low)
// ---------------------------------------------------------------------------
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for learn/classify, cnt held at 0
//   LEARN    | writing kernel words (port 0) and weight words (all ports)
//   CLASSIFY | reading weight words, kernel ports on fixed addresses
//   DONE     | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module neural_net_seq #(
    parameter int ADDR_W  = 5,
    parameter int N_KERN  = 2,
    parameter int W_WORDS = 8,
    parameter int W_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      learn,
    input  logic                      classify,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      en,
    output logic [N_KERN*ADDR_W-1:0]  kmem_a,
    output logic [N_KERN-1:0]         kmem_web,
    output logic                      kmem_csb,
    output logic                      kmem_oeb,
    output logic [W_PORTS*ADDR_W-1:0] wmem_a,
    output logic [W_PORTS-1:0]        wmem_web,
    output logic                      wmem_csb,
    output logic                      wmem_oeb
);

    localparam int W_ROWS    = W_WORDS / W_PORTS;
    localparam int LEARN_CYC = (N_KERN > W_ROWS) ? N_KERN : W_ROWS;
    localparam int CLS_CYC   = W_ROWS;
    localparam int MAX_CYC   = (LEARN_CYC > CLS_CYC) ? LEARN_CYC : CLS_CYC;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    // Compare constants sized to the counter so no comparison mixes widths.
    localparam logic [CNT_W-1:0] K_END  = CNT_W'(N_KERN);
    localparam logic [CNT_W-1:0] W_END  = CNT_W'(W_ROWS);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LEARN_CYC - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLS_CYC - 1);

    if (W_WORDS % W_PORTS != 0) begin : g_bad_ports
        $error("neural_net_seq: W_WORDS must be a multiple of W_PORTS");
    end
    if (N_KERN < 1 || N_KERN > 2**ADDR_W) begin : g_bad_kern
        $error("neural_net_seq: N_KERN out of range");
    end
    if (W_WORDS > 2**ADDR_W) begin : g_bad_words
        $error("neural_net_seq: W_WORDS exceeds address space");
    end

    typedef enum logic [1:0] {
        IDLE,
        LEARN,
        CLASSIFY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign kmem_csb = 1'b0;
    assign kmem_oeb = 1'b0;
    assign wmem_csb = 1'b0;
    assign wmem_oeb = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        en        = 1'b0;
        kmem_a    = '0;
        kmem_web  = '1;
        wmem_a    = '0;
        wmem_web  = '1;

        case (state)
            IDLE: begin
                if (learn) begin
                    state_nxt = LEARN;
                end else if (classify) begin
                    state_nxt = CLASSIFY;
                end
            end

            LEARN: begin
                busy = 1'b1;
                // Only port 0 carries kernel writes; abort gates the strobe
                // but leaves the address visible.
                if (cnt < K_END) begin
                    kmem_a[0 +: ADDR_W] = ADDR_W'(cnt);
                    kmem_web[0]         = abort;
                end
                if (cnt < W_END) begin
                    for (int p = 0; p < W_PORTS; p++) begin
                        wmem_a[p*ADDR_W +: ADDR_W] =
                            ADDR_W'(cnt) * ADDR_W'(W_PORTS) + ADDR_W'(p);
                        wmem_web[p] = abort;
                    end
                end
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == L_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            CLASSIFY: begin
                busy = 1'b1;
                en   = (cnt == '0) && !abort;
                for (int k = 0; k < N_KERN; k++) begin
                    kmem_a[k*ADDR_W +: ADDR_W] = ADDR_W'(k);
                end
                for (int p = 0; p < W_PORTS; p++) begin
                    wmem_a[p*ADDR_W +: ADDR_W] =
                        ADDR_W'(cnt) * ADDR_W'(W_PORTS) + ADDR_W'(p);
                end
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == C_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neural_net_seq.sv
module tb_neural_net_seq;

    localparam int ADDR_W  = 5;
    localparam int N_KERN  = 2;
    localparam int W_WORDS = 8;
    localparam int W_PORTS = 2;
    localparam int ROWS    = W_WORDS / W_PORTS;
    localparam int L_LEN   = (N_KERN > ROWS) ? N_KERN : ROWS;
    localparam int C_LEN   = ROWS;

    logic clk = 1'b0;
    logic rst_n;
    logic learn = 1'b0, classify = 1'b0, abort = 1'b0;
    logic busy, done, en;
    logic [N_KERN*ADDR_W-1:0]  kmem_a;
    logic [N_KERN-1:0]         kmem_web;
    logic                      kmem_csb, kmem_oeb;
    logic [W_PORTS*ADDR_W-1:0] wmem_a;
    logic [W_PORTS-1:0]        wmem_web;
    logic                      wmem_csb, wmem_oeb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    neural_net_seq #(
        .ADDR_W(ADDR_W), .N_KERN(N_KERN), .W_WORDS(W_WORDS), .W_PORTS(W_PORTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .learn(learn), .classify(classify), .abort(abort),
        .busy(busy), .done(done), .en(en),
        .kmem_a(kmem_a), .kmem_web(kmem_web),
        .kmem_csb(kmem_csb), .kmem_oeb(kmem_oeb),
        .wmem_a(wmem_a), .wmem_web(wmem_web),
        .wmem_csb(wmem_csb), .wmem_oeb(wmem_oeb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: which operation is in flight and how many cycles of
    // it have elapsed (0 none, 1 learn, 2 classify, 3 completion cycle).
    int op   = 0;
    int step = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op   <= 0;
            step <= 0;
        end else begin
            if (op == 0) begin
                if (learn)         begin op <= 1; step <= 0; end
                else if (classify) begin op <= 2; step <= 0; end
            end else if (op == 3) begin
                op <= 0;
            end else begin
                if (abort) op <= 0;
                else if (step == ((op == 1) ? L_LEN : C_LEN) - 1) op <= 3;
                else step <= step + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N_KERN*ADDR_W-1:0]  e_ka;
        logic [N_KERN-1:0]         e_kw;
        logic [W_PORTS*ADDR_W-1:0] e_wa;
        logic [W_PORTS-1:0]        e_ww;
        logic e_busy, e_done, e_en;
        e_ka = '0; e_kw = '1; e_wa = '0; e_ww = '1;
        e_busy = (op == 1 || op == 2);
        e_done = (op == 3);
        e_en   = 1'b0;
        if (op == 1) begin
            if (step < N_KERN) begin
                e_ka[0 +: ADDR_W] = step[ADDR_W-1:0];
                e_kw[0] = abort;
            end
            if (step < ROWS) begin
                for (int p = 0; p < W_PORTS; p++) begin
                    int w;
                    w = step * W_PORTS + p;
                    e_wa[p*ADDR_W +: ADDR_W] = w[ADDR_W-1:0];
                    e_ww[p] = abort;
                end
            end
        end else if (op == 2) begin
            e_en = (step == 0) && !abort;
            for (int k = 0; k < N_KERN; k++) e_ka[k*ADDR_W +: ADDR_W] = k[ADDR_W-1:0];
            for (int p = 0; p < W_PORTS; p++) begin
                int w;
                w = step * W_PORTS + p;
                e_wa[p*ADDR_W +: ADDR_W] = w[ADDR_W-1:0];
            end
        end
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("en", 64'(en), 64'(e_en));
        check("kmem_a", 64'(kmem_a), 64'(e_ka));
        check("kmem_web", 64'(kmem_web), 64'(e_kw));
        check("wmem_a", 64'(wmem_a), 64'(e_wa));
        check("wmem_web", 64'(wmem_web), 64'(e_ww));
        check("cs_oe", 64'({kmem_csb, kmem_oeb, wmem_csb, wmem_oeb}), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_kweb", 64'(kmem_web), 64'(2'b11));
        check("rst_wweb", 64'(wmem_web), 64'(2'b11));
        check("rst_wa", 64'(wmem_a), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // learn pulse
        learn = 1'b1; tick(); learn = 1'b0;
        @(negedge clk);
        check("l0_busy", 64'(busy), 64'(1));
        check("l0_kweb", 64'(kmem_web), 64'(2'b10));
        check("l0_wweb", 64'(wmem_web), 64'(2'b00));
        check("l0_wa", 64'(wmem_a), 64'(10'b00001_00000));
        tick(); tick();
        @(negedge clk);
        check("l2_kweb", 64'(kmem_web), 64'(2'b11));
        check("l2_wa", 64'(wmem_a), 64'(10'b00101_00100));
        tick(); tick();
        @(negedge clk);
        check("l_done", 64'(done), 64'(1));
        check("l_done_busy", 64'(busy), 64'(0));
        tick();
        @(negedge clk);
        check("l_idle_done", 64'(done), 64'(0));

        // classify held
        classify = 1'b1; tick();
        @(negedge clk);
        check("c0_en", 64'(en), 64'(1));
        check("c0_ka", 64'(kmem_a), 64'(10'b00001_00000));
        check("c0_wweb", 64'(wmem_web), 64'(2'b11));
        tick();
        @(negedge clk);
        check("c1_en", 64'(en), 64'(0));
        check("c1_wa", 64'(wmem_a), 64'(10'b00011_00010));
        tick(); tick(); tick();
        @(negedge clk);
        check("c_done", 64'(done), 64'(1));
        tick();
        @(negedge clk);
        check("c_idle", 64'(busy), 64'(0));
        tick();
        @(negedge clk);
        check("c_restart_en", 64'(en), 64'(1));
        classify = 1'b0;
        repeat (6) tick();

        // learn and classify together: learn wins
        learn = 1'b1; classify = 1'b1; tick(); learn = 1'b0; classify = 1'b0;
        @(negedge clk);
        check("both_kweb", 64'(kmem_web), 64'(2'b10));
        check("both_en", 64'(en), 64'(0));
        repeat (6) tick();

        // abort at learn cnt 2
        learn = 1'b1; tick(); learn = 1'b0; tick(); tick();
        abort = 1'b1;
        @(negedge clk);
        check("ab_wweb", 64'(wmem_web), 64'(2'b11));
        check("ab_busy", 64'(busy), 64'(1));
        tick(); abort = 1'b0;
        @(negedge clk);
        check("ab_idle", 64'(busy), 64'(0));
        check("ab_nodone", 64'(done), 64'(0));
        tick();
        @(negedge clk);
        check("ab_nodone2", 64'(done), 64'(0));

        // learn during classify is ignored
        classify = 1'b1; tick(); classify = 1'b0;
        learn = 1'b1; tick(); tick(); learn = 1'b0; tick(); tick();
        @(negedge clk);
        check("cl_done", 64'(done), 64'(1));
        tick();
        @(negedge clk);
        check("cl_no_learn", 64'(busy), 64'(0));
        repeat (2) tick();

        // asynchronous reset at learn cnt 1
        learn = 1'b1; tick(); learn = 1'b0; tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'(0));
        check("ar_kweb", 64'(kmem_web), 64'(2'b11));
        check("ar_wweb", 64'(wmem_web), 64'(2'b11));
        check("ar_wa", 64'(wmem_a), 64'(0));
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("ar_rel_busy", 64'(busy), 64'(0));
        check("ar_rel_done", 64'(done), 64'(0));
        tick();
        @(negedge clk);
        check("ar_rel_done2", 64'(done), 64'(0));

        // abort on the last learn cycle beats completion
        learn = 1'b1; tick(); learn = 1'b0; tick(); tick(); tick();
        abort = 1'b1;
        @(negedge clk);
        check("al_wweb", 64'(wmem_web), 64'(2'b11));
        tick(); abort = 1'b0;
        @(negedge clk);
        check("al_nodone", 64'(done), 64'(0));
        check("al_idle", 64'(busy), 64'(0));

        // abort in IDLE is ignored
        abort = 1'b1; classify = 1'b1; tick(); abort = 1'b0; classify = 1'b0;
        @(negedge clk);
        check("ai_en", 64'(en), 64'(1));
        check("ai_busy", 64'(busy), 64'(1));
        repeat (6) tick();

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
